// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 format widths, operand classes and constants
package fp_pkg;
  localparam int E32 = 8;
  localparam int F32 = 23;
  localparam int BIAS32 = 127;
  localparam int E64 = 11;
  localparam int F64 = 52;
  localparam int BIAS64 = 1023;
  localparam logic [63:0] CANON_NAN = '1;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;
  function automatic int exp_w(input int n);
    return n == 64 ? E64 : E32;
  endfunction
  function automatic int frac_w(input int n);
    return n == 64 ? F64 : F32;
  endfunction
  function automatic int bias_of(input int n);
    return n == 64 ? BIAS64 : BIAS32;
  endfunction
endpackage

// File: rtl/fp_align_if.sv
// fp_align_if: operand-pair input and aligned-pair output handshake bus of fp_align
interface fp_align_if import fp_pkg::*; #(parameter int N = 32);
  localparam int E = exp_w(N);
  localparam int F = frac_w(N);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic out_valid;
  logic out_ready;
  logic out_sign_l;
  logic out_sign_s;
  logic [E-1:0] out_exp;
  logic [F:0] out_man_l;
  logic [F+3:0] out_man_s;
  logic out_eff_sub;
  logic out_special;
  logic [N-1:0] out_special_val;
  modport master (
    output in_valid, a, b, out_ready,
    input in_ready, out_valid, out_sign_l, out_sign_s, out_exp, out_man_l, out_man_s,
    input out_eff_sub, out_special, out_special_val
  );
  modport slave (
    input in_valid, a, b, out_ready,
    output in_ready, out_valid, out_sign_l, out_sign_s, out_exp, out_man_l, out_man_s,
    output out_eff_sub, out_special, out_special_val
  );
endinterface

// File: rtl/fp_classify.sv
// fp_classify: split a raw IEEE-754 operand into class, sign, exponent and fraction
module fp_classify import fp_pkg::*; #(
  parameter int N = 32,
  localparam int E = exp_w(N),
  localparam int F = frac_w(N)
) (
  input  logic [N-1:0] x,
  output fp_class_e    cls,
  output logic         sign,
  output logic [E-1:0] expo,
  output logic [F-1:0] frac
);
  assign sign = x[N-1];
  assign expo = x[N-2:F];
  assign frac = x[F-1:0];
  assign cls = expo == '0 ? ZERO : expo != '1 ? NORM : frac == '0 ? INF : NAN;
endmodule

// File: rtl/fp_align.sv
// fp_align: 2-stage swap/align front end of an FP adder; FP_ALIGN_STICKY_EN enables the sticky bit
module fp_align import fp_pkg::*; #(parameter int N = 32) (
  input logic clk,
  input logic rst,
  fp_align_if.slave bus
);
  localparam int E = exp_w(N);
  localparam int F = frac_w(N);
  fp_class_e ca, cb;
  logic sa, sb;
  logic [E-1:0] ea, eb;
  logic [F-1:0] fa, fb;
  fp_classify #(.N(N)) u_ca (.x(bus.a), .cls(ca), .sign(sa), .expo(ea), .frac(fa));
  fp_classify #(.N(N)) u_cb (.x(bus.b), .cls(cb), .sign(sb), .expo(eb), .frac(fb));
  logic swap, any_nan, inf_clash, special;
  logic [N-1:0] special_val;
  // choose the larger magnitude (ties go to a) and resolve pairs whose sum is already known
  always_comb begin
    swap = eb > ea || (eb == ea && fb > fa);
    any_nan = ca == NAN || cb == NAN;
    inf_clash = ca == INF && cb == INF && sa != sb;
    special = any_nan || ca inside {INF, ZERO} || cb inside {INF, ZERO};
    special_val = any_nan || inf_clash ? CANON_NAN[N-1:0] :
                  ca == INF ? bus.a :
                  cb == INF ? bus.b :
                  ca == ZERO && cb == ZERO ? {sa & sb, {(N-1){1'b0}}} :
                  ca == ZERO ? bus.b : bus.a;
  end
  logic v1, v2, en2;
  logic sp1, sl1, ss1;
  logic [N-1:0] sv1;
  logic [E-1:0] e1, d1;
  logic [F-1:0] fl1, fs1;
  assign en2 = !v2 || bus.out_ready;
  assign bus.in_ready = !v1 || en2;
  // stage 1: classification, swapped operand fields and exponent difference
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      sp1 <= 1'b0;
      sv1 <= '0;
      sl1 <= 1'b0;
      ss1 <= 1'b0;
      e1 <= '0;
      d1 <= '0;
      fl1 <= '0;
      fs1 <= '0;
    end else if (bus.in_ready) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        sp1 <= special;
        sv1 <= special_val;
        sl1 <= swap ? sb : sa;
        ss1 <= swap ? sa : sb;
        e1 <= swap ? eb : ea;
        d1 <= swap ? eb - ea : ea - eb;
        fl1 <= swap ? fb : fa;
        fs1 <= swap ? fa : fb;
      end
    end
  logic [F+2:0] gr;
  logic sticky;
  // shift {hidden, fraction, G, R} right by d; S collects everything that falls below R
  always_comb begin
    gr = {1'b1, fs1, 2'b00} >> d1;
`ifdef FP_ALIGN_STICKY_EN
    sticky = d1 > E'(2) && |({1'b1, fs1} & ~({(F+1){1'b1}} << (d1 - E'(2))));
`else
    sticky = 1'b0;
`endif
  end
  logic o_sp, o_sl, o_ss;
  logic [N-1:0] o_val;
  logic [E-1:0] o_exp;
  logic [F:0] o_ml;
  logic [F+3:0] o_ms;
  // stage 2: aligned pair, datapath fields forced to zero when the result is already known
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2 <= 1'b0;
      o_sp <= 1'b0;
      o_val <= '0;
      o_sl <= 1'b0;
      o_ss <= 1'b0;
      o_exp <= '0;
      o_ml <= '0;
      o_ms <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        o_sp <= sp1;
        o_val <= sp1 ? sv1 : '0;
        o_sl <= sl1;
        o_ss <= ss1;
        o_exp <= sp1 ? '0 : e1;
        o_ml <= sp1 ? '0 : {1'b1, fl1};
        o_ms <= sp1 ? '0 : {gr, sticky};
      end
    end
  assign bus.out_valid = v2;
  assign bus.out_special = o_sp;
  assign bus.out_special_val = o_val;
  assign bus.out_sign_l = o_sl;
  assign bus.out_sign_s = o_ss;
  assign bus.out_eff_sub = o_sl ^ o_ss;
  assign bus.out_exp = o_exp;
  assign bus.out_man_l = o_ml;
  assign bus.out_man_s = o_ms;
endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 SHALL have parameter N, default 32, giving the IEEE-754 operand width; legal values are 32 and 64.
REQ-002 SHALL derive E (exponent width: 8 or 11), F (fraction width: 23 or 52) and BIAS from N via the shared package.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  the operand pair on a/b is valid.
REQ-006 in_ready  output  1  fp_align accepts a/b this cycle.
REQ-007 a, b  input  N  raw IEEE-754 operands.
REQ-008 out_valid  output  1  the aligned pair is valid.
REQ-009 out_ready  input  1  the downstream adder consumes the pair.
REQ-010 out_sign_l, out_sign_s  output  1  signs of the larger- and smaller-magnitude operands.
REQ-011 out_exp  output  E  exponent of the larger operand, which is the common exponent.
REQ-012 out_man_l  output  F+1  larger-operand mantissa with the hidden bit.
REQ-013 out_man_s  output  F+4  aligned smaller-operand mantissa, laid out {hidden, fraction, G, R, S}.
REQ-014 out_eff_sub  output  1  effective subtraction, equal to sign_l XOR sign_s.
REQ-015 out_special, out_special_val  output  1, N  the result is fully determined; out_special_val is that result.

Function
REQ-016 SHALL accept a transfer when in_valid and in_ready are both high, and SHALL emit a transfer when out_valid and out_ready are both high.
REQ-017 SHALL be a 2-stage pipeline.
- Stage 1 registers: classification, swap, and the exponent difference d = exp_l - exp_s.
- Stage 2 registers: the shifted mantissa.
- Latency is exactly 2 cycles when there is no backpressure.
REQ-018 in_ready SHALL be high when stage 1 is empty or stage 1 can advance; stage 1 advances when stage 2 is empty or out_ready is high.
- Bubbles collapse.
- Throughput is 1 transfer per cycle.
REQ-019 While out_valid is high and out_ready is low, every out_* signal SHALL hold stable and no data SHALL be lost or duplicated.
REQ-020 The larger operand SHALL be chosen as follows:
- the operand with the larger exponent field;
- on equal exponents, the operand with the larger fraction;
- on full magnitude equality, operand a.
REQ-021 The smaller mantissa SHALL be formed and shifted as follows:
- form {1, frac, 3'b000};
- shift right by d;
- the G and R bits take the first two bits shifted out.
REQ-022 For shifts of F+4 or more, out_man_s SHALL have all non-sticky bits equal to zero.
REQ-023 An operand with exponent field 0 SHALL be treated as zero; denormals are flushed.
REQ-024 The special-case rules SHALL be applied in this priority order:
- any NaN → out_special_val = all-ones;
- +inf combined with -inf → all-ones;
- otherwise, if either operand is inf → that inf;
- both operands zero → -0 if both signs are negative, else +0;
- one operand zero → the other operand.
REQ-025 When out_special is high, out_man_l, out_man_s and out_exp SHALL be 0.
REQ-026 When out_special is low, out_special_val SHALL be 0.

Reset
REQ-027 While rst is high, the following SHALL hold, independent of clk:
- both stage-valid flags are 0;
- out_valid is 0;
- every out_* data signal is 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Operands in flight when reset is asserted SHALL be discarded and never emitted.

Configuration
REQ-030 With FP_ALIGN_STICKY_EN defined, the S bit SHALL be the OR of all bits shifted out beyond R, including the full-flush case.
REQ-031 Without FP_ALIGN_STICKY_EN, the S bit SHALL be tied to 0 and the sticky reduction logic SHALL be absent.

Structure
REQ-032 Package fp_pkg SHALL hold:
- E, F and BIAS for each N;
- the class enum (ZERO, NORM, INF, NAN);
- the canonical NaN constant (all-ones).
REQ-033 fp_align SHALL instantiate sub-module fp_classify twice, once per operand; fp_classify is combinational (operand → class, sign, exponent, fraction).

Verification (N=32)
REQ-034 a=0x40400000, b=0x3F800000 → 2 cycles later: out_exp=0x80, out_man_l=0xC00000, out_man_s=0x2000000, out_eff_sub=0, out_special=0.
REQ-035 a=0x3F800000, b=0xC0400000 → out_sign_l=1, out_sign_s=0, out_eff_sub=1, out_man_s=0x2000000.
REQ-036 a=0x3F800000, b=0x32800000 (d=26) → out_man_s=0x0000001 with FP_ALIGN_STICKY_EN, 0x0000000 without it.
REQ-037 Special operand pairs:
- a=0x7F800000, b=0xFF800000 → out_special=1, out_special_val=0xFFFFFFFF;
- a=0x80000000, b=0x80000000 → out_special_val=0x80000000;
- a=0x00000000, b=0xC0000000 → out_special_val=0xC0000000.
REQ-038 Backpressure: stream 6 pairs with out_ready held low for 3 cycles.
- in_ready falls after 2 pairs are accepted.
- Outputs stay stable while stalled.
- All 6 pairs emerge in order with none lost or duplicated.
REQ-039 Reset mid-flight: assert rst with 2 pairs in flight.
- out_valid falls asynchronously.
- Neither in-flight pair is emitted after release.
- The next pair appears 2 cycles after it is accepted.
